// File: rtl/rv_timer_pkg.sv
// Shared register map, CTRL layout and bus constants for the MMIO timer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rv_timer_pkg;

  // Register offsets within the 256-byte window (word aligned).
  localparam logic [7:0] TMR_CTRL   = 8'h00;
  localparam logic [7:0] TMR_PSC    = 8'h04;
  localparam logic [7:0] TMR_ARR    = 8'h08;
  localparam logic [7:0] TMR_CNT    = 8'h0C;
  localparam logic [7:0] TMR_STATUS = 8'h10;
  localparam logic [7:0] TMR_CMP    = 8'h14;

  // CTRL bit positions as seen on the bus.
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_IRQ_EN_BIT  = 1;
  localparam int CTRL_ONESHOT_BIT = 2;

  // STATUS bit position of the update flag.
  localparam int STATUS_UIF_BIT = 0;

  // funct3 encoding of a full-word store (SW).
  localparam logic [2:0] FUNCT3_SW = 3'b010;

  typedef struct packed {
    logic oneshot;
    logic irq_en;
    logic en;
  } tmr_ctrl_t;

  // Unpack a bus word into the CTRL fields; upper bits are discarded.
  function automatic tmr_ctrl_t ctrl_from_word(input logic [31:0] w);
    tmr_ctrl_t c;
    c.en      = w[CTRL_EN_BIT];
    c.irq_en  = w[CTRL_IRQ_EN_BIT];
    c.oneshot = w[CTRL_ONESHOT_BIT];
    return c;
  endfunction

  // Pack CTRL fields into a bus word; unused bits read as zero.
  function automatic logic [31:0] ctrl_to_word(input tmr_ctrl_t c);
    logic [31:0] w;
    w                   = '0;
    w[CTRL_EN_BIT]      = c.en;
    w[CTRL_IRQ_EN_BIT]  = c.irq_en;
    w[CTRL_ONESHOT_BIT] = c.oneshot;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by (psc+1) while enabled, emitting a one-cycle tick at terminal count.
// Latency: tick is combinational from the registered divider count; count updates each edge.
// Backpressure: none; a psc write restarts the divider from zero.
module timer_prescaler (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] psc,
  input  logic        psc_wr,
  output logic        tick
);

  logic [15:0] psc_cnt_q;
  logic [15:0] psc_cnt_d;

  assign tick = en & (psc_cnt_q == psc);

  // Next divider count: advance while enabled, restart on tick, disable or PSC rewrite.
  always_comb begin
    psc_cnt_d = psc_cnt_q + 16'd1;
    if (psc_wr || !en || tick) begin
      psc_cnt_d = '0;
    end
  end

  // Divider count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/rv32i_mmio_timer.sv
// Memory-mapped 32-bit auto-reload timer on the RV32I data port; optional PWM via RV_TIMER_PWM_EN.
// Latency: reads are combinational (0 cycles); SW stores take effect on the same edge.
// Backpressure: none; the bus never stalls, sub-word stores to the window are dropped.
module rv32i_mmio_timer
  import rv_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] ARR_RESET = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_wr_en,
  input  logic [31:0] dAddr,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] dWdata,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        pwm_o
);

  // Architectural state.
  tmr_ctrl_t   ctrl_q, ctrl_d;
  logic [15:0] psc_q,  psc_d;
  logic [31:0] arr_q,  arr_d;
  logic [31:0] cnt_q,  cnt_d;
  logic        uif_q,  uif_d;

  // Bus decode.
  logic [7:0]  off;
  logic        wr_sw;
  logic        wr_ctrl, wr_psc, wr_arr, wr_cnt, wr_status;
  logic        unused_addr_lsb;

  // Counter control.
  logic        tick;
  logic        update;

  // Read-back of the compare register (zero when PWM is not built).
  logic [31:0] cmp_rd;

  // Byte lanes inside a word are irrelevant: the window is word-addressed only.
  assign off             = {dAddr[7:2], 2'b00};
  assign unused_addr_lsb = ^dAddr[1:0];

  assign sel   = (dAddr[31:8] == BASE_ADDR[31:8]);
  assign wr_sw = sel & d_wr_en & (mem_funct3 == FUNCT3_SW);

  assign wr_ctrl   = wr_sw & (off == TMR_CTRL);
  assign wr_psc    = wr_sw & (off == TMR_PSC);
  assign wr_arr    = wr_sw & (off == TMR_ARR);
  assign wr_cnt    = wr_sw & (off == TMR_CNT);
  assign wr_status = wr_sw & (off == TMR_STATUS);

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (ctrl_q.en),
    .psc    (psc_q),
    .psc_wr (wr_psc),
    .tick   (tick)
  );

  // Reload happens when a tick finds CNT at or past ARR, so lowering ARR below
  // the running count reloads on the next tick instead of wrapping through 2^32.
  assign update = tick & (cnt_q >= arr_q);

  assign irq = uif_q & ctrl_q.irq_en;

  // Next-state for the register file and counter; software writes are applied
  // last so they override hardware updates, except UIF where the set wins.
  always_comb begin
    ctrl_d = ctrl_q;
    psc_d  = psc_q;
    arr_d  = arr_q;
    cnt_d  = cnt_q;
    uif_d  = uif_q;

    if (update && ctrl_q.oneshot) begin
      ctrl_d.en = 1'b0;
    end
    if (wr_ctrl) begin
      ctrl_d = ctrl_from_word(dWdata);
    end

    if (wr_psc) begin
      psc_d = dWdata[15:0];
    end

    if (wr_arr) begin
      arr_d = dWdata;
    end

    if (tick) begin
      cnt_d = update ? 32'd0 : (cnt_q + 32'd1);
    end
    if (wr_cnt) begin
      cnt_d = dWdata;
    end

    if (wr_status && dWdata[STATUS_UIF_BIT]) begin
      uif_d = 1'b0;
    end
    if (update) begin
      uif_d = 1'b1;
    end
  end

  // Register file and counter flops; reset overrides any same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
      psc_q  <= '0;
      arr_q  <= ARR_RESET;
      cnt_q  <= '0;
      uif_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      psc_q  <= psc_d;
      arr_q  <= arr_d;
      cnt_q  <= cnt_d;
      uif_q  <= uif_d;
    end
  end

`ifdef RV_TIMER_PWM_EN
  logic        wr_cmp;
  logic [31:0] cmp_q, cmp_d;
  logic        pwm_q, pwm_d;

  assign wr_cmp = wr_sw & (off == TMR_CMP);

  // Compare register update and PWM level from pre-edge EN/CNT (one-cycle lag).
  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp) begin
      cmp_d = dWdata;
    end
    pwm_d = ctrl_q.en & (cnt_q < cmp_q);
  end

  // Compare and PWM output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      pwm_q <= pwm_d;
    end
  end

  assign cmp_rd = cmp_q;
  assign pwm_o  = pwm_q;
`else
  assign cmp_rd = '0;
  assign pwm_o  = 1'b0;
`endif

  // Read mux: full word regardless of access width; zero outside the window.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        TMR_CTRL:   rdata = ctrl_to_word(ctrl_q);
        TMR_PSC:    rdata = {16'd0, psc_q};
        TMR_ARR:    rdata = arr_q;
        TMR_CNT:    rdata = cnt_q;
        TMR_STATUS: rdata = {31'd0, uif_q};
        TMR_CMP:    rdata = cmp_rd;
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mmio_timer.sv
// Directed, table-driven bench for rv32i_mmio_timer; PWM checks follow RV_TIMER_PWM_EN.
// Latency: one table record per clock; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_rv32i_mmio_timer;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [2:0]  SW   = 3'b010;
  localparam logic [7:0]  C = 8'h00, P = 8'h04, A = 8'h08, N = 8'h0C, S = 8'h10, M = 8'h14;

`ifdef RV_TIMER_PWM_EN
  localparam bit          PWM_ON = 1'b1;
  localparam logic [31:0] CMP_RB = 32'd7;
`else
  localparam bit          PWM_ON = 1'b0;
  localparam logic [31:0] CMP_RB = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        d_wr_en;
  logic [31:0] dAddr;
  logic [2:0]  mem_funct3;
  logic [31:0] dWdata;
  logic        sel;
  logic [31:0] rdata;
  logic        irq;
  logic        pwm_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  rv32i_mmio_timer #(
    .BASE_ADDR (BASE),
    .ARR_RESET (32'hFFFF_FFFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_wr_en    (d_wr_en),
    .dAddr      (dAddr),
    .mem_funct3 (mem_funct3),
    .dWdata     (dWdata),
    .sel        (sel),
    .rdata      (rdata),
    .irq        (irq),
    .pwm_o      (pwm_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input logic [7:0] off, input logic [2:0] f3,
                              input logic [31:0] wd, input logic [31:0] e, input logic ei);
    vec_t v;
    v.we = we; v.off = off; v.f3 = f3; v.wd = wd; v.exp_rd = e; v.exp_irq = ei;
    return v;
  endfunction

  function automatic vec_t R(input logic [7:0] off, input logic [31:0] e, input logic ei);
    return mk(1'b0, off, SW, 32'd0, e, ei);
  endfunction

  function automatic vec_t W(input logic [7:0] off, input logic [31:0] wd,
                             input logic [31:0] e, input logic ei);
    return mk(1'b1, off, SW, wd, e, ei);
  endfunction

  task automatic drive(input logic we, input logic [7:0] off, input logic [2:0] f3,
                       input logic [31:0] wd);
    d_wr_en    = we;
    dAddr      = BASE | {24'd0, off};
    mem_funct3 = f3;
    dWdata     = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          high_cnt;
    logic        ep;
    logic [31:0] exp_regs [6];
    logic [7:0]  reg_offs [6];

    // Reset state and basic map.
    tbl.push_back(R(C, 32'h0, 0));
    tbl.push_back(R(P, 32'h0, 0));
    tbl.push_back(R(A, 32'hFFFF_FFFF, 0));
    tbl.push_back(R(N, 32'h0, 0));
    tbl.push_back(R(S, 32'h0, 0));
    tbl.push_back(R(M, 32'h0, 0));
    // PSC=0, ARR=3, EN|IRQ_EN: count 1,2,3,0 then W1C, then W1C racing a reload.
    tbl.push_back(W(P, 32'd0, 32'h0, 0));
    tbl.push_back(W(A, 32'd3, 32'hFFFF_FFFF, 0));
    tbl.push_back(W(C, 32'h3, 32'h0, 0));
    tbl.push_back(R(N, 32'd0, 0));
    tbl.push_back(R(N, 32'd1, 0));
    tbl.push_back(R(N, 32'd2, 0));
    tbl.push_back(R(N, 32'd3, 0));
    tbl.push_back(R(N, 32'd0, 1));
    tbl.push_back(R(S, 32'd1, 1));
    tbl.push_back(W(S, 32'd1, 32'd1, 1));
    tbl.push_back(W(S, 32'd1, 32'd0, 0));
    tbl.push_back(R(S, 32'd1, 1));
    tbl.push_back(W(C, 32'h0, 32'h3, 1));
    tbl.push_back(W(S, 32'd1, 32'd1, 0));
    tbl.push_back(R(N, 32'd2, 0));
    tbl.push_back(R(S, 32'd0, 0));
    // Oneshot: PSC=2, ARR=1.
    tbl.push_back(W(P, 32'd2, 32'd0, 0));
    tbl.push_back(W(A, 32'd1, 32'd3, 0));
    tbl.push_back(W(N, 32'd0, 32'd2, 0));
    tbl.push_back(W(C, 32'h5, 32'h0, 0));
    tbl.push_back(R(N, 32'd0, 0));
    tbl.push_back(R(N, 32'd0, 0));
    tbl.push_back(R(N, 32'd0, 0));
    tbl.push_back(R(N, 32'd1, 0));
    tbl.push_back(R(N, 32'd1, 0));
    tbl.push_back(R(N, 32'd1, 0));
    tbl.push_back(R(C, 32'h4, 0));
    tbl.push_back(R(N, 32'd0, 0));
    tbl.push_back(R(N, 32'd0, 0));
    tbl.push_back(R(N, 32'd0, 0));
    tbl.push_back(R(S, 32'd1, 0));
    tbl.push_back(W(S, 32'd1, 32'd1, 0));
    tbl.push_back(R(S, 32'd0, 0));
    // Sub-word stores, unmapped offset, CMP, byte offset within a word.
    tbl.push_back(mk(1'b1, C, 3'b000, 32'd1, 32'h4, 0));
    tbl.push_back(R(C, 32'h4, 0));
    tbl.push_back(mk(1'b1, A, 3'b001, 32'd5, 32'd1, 0));
    tbl.push_back(R(A, 32'd1, 0));
    tbl.push_back(W(8'h20, 32'hFFFF_FFFF, 32'd0, 0));
    tbl.push_back(R(8'h20, 32'd0, 0));
    tbl.push_back(R(P, 32'd2, 0));
    tbl.push_back(W(M, 32'd7, 32'd0, 0));
    tbl.push_back(R(M, CMP_RB, 0));
    tbl.push_back(R(8'h0B, 32'd1, 0));
    // CNT write racing a tick, ARR=0, W1C racing reload, CTRL write vs oneshot clear.
    tbl.push_back(W(P, 32'd0, 32'd2, 0));
    tbl.push_back(W(A, 32'd100, 32'd1, 0));
    tbl.push_back(W(N, 32'd5, 32'd0, 0));
    tbl.push_back(W(C, 32'h1, 32'h4, 0));
    tbl.push_back(R(N, 32'd5, 0));
    tbl.push_back(W(N, 32'h10, 32'd6, 0));
    tbl.push_back(R(N, 32'h10, 0));
    tbl.push_back(R(N, 32'h11, 0));
    tbl.push_back(W(A, 32'd0, 32'd100, 0));
    tbl.push_back(R(N, 32'h13, 0));
    tbl.push_back(R(N, 32'd0, 0));
    tbl.push_back(R(S, 32'd1, 0));
    tbl.push_back(W(S, 32'd1, 32'd1, 0));
    tbl.push_back(R(S, 32'd1, 0));
    tbl.push_back(R(N, 32'd0, 0));
    tbl.push_back(W(C, 32'h5, 32'h1, 0));
    tbl.push_back(W(C, 32'h7, 32'h5, 0));
    tbl.push_back(R(C, 32'h7, 1));
    tbl.push_back(R(C, 32'h6, 1));

    reset = 1'b1;
    drive(1'b0, C, SW, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle cycle just out of reset: PWM low, window selected.
    @(negedge clk);
    check("reset pwm_o", {31'd0, pwm_o}, 32'd0);
    check("reset sel", {31'd0, sel}, 32'd1);
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].off, tbl[i].f3, tbl[i].wd);
      @(negedge clk);
      check($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rd);
      check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
      step();
    end

    // PWM period: ARR=9, CMP=4, PSC=0; reset lands mid-count together with a CNT write.
    drive(1'b1, P, SW, 32'd0); step();
    drive(1'b1, A, SW, 32'd9); step();
    drive(1'b1, M, SW, 32'd4); step();
    drive(1'b1, N, SW, 32'd0); step();
    drive(1'b1, S, SW, 32'd1); step();
    drive(1'b1, C, SW, 32'h1); step();
    high_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      if (i == 23) begin
        reset = 1'b1;
        drive(1'b1, N, SW, 32'h55);
      end else begin
        drive(1'b0, N, SW, 32'd0);
      end
      @(negedge clk);
      ep = PWM_ON && (i > 0) && (((i - 1) % 10) < 4);
      check($sformatf("pwm cyc%0d cnt", i), rdata, 32'(i % 10));
      check($sformatf("pwm cyc%0d pwm_o", i), {31'd0, pwm_o}, {31'd0, ep});
      if (i < 20 && pwm_o) high_cnt++;
      step();
    end
    check("pwm high cycles in 20", 32'(high_cnt), PWM_ON ? 32'd8 : 32'd0);

    // Everything back at reset values after the mid-count reset.
    reset = 1'b0;
    reg_offs = '{C, P, A, N, S, M};
    exp_regs = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, reg_offs[k], SW, 32'd0);
      @(negedge clk);
      check($sformatf("post-reset reg%0d", k), rdata, exp_regs[k]);
      check($sformatf("post-reset pwm%0d", k), {31'd0, pwm_o}, 32'd0);
      check($sformatf("post-reset irq%0d", k), {31'd0, irq}, 32'd0);
      step();
    end

    // Window decode.
    dAddr = 32'h2000_0008;
    #1;
    check("sel outside", {31'd0, sel}, 32'd0);
    check("rdata outside", rdata, 32'd0);
    dAddr = 32'h1000_0100;
    #1;
    check("sel past window", {31'd0, sel}, 32'd0);
    dAddr = 32'h1000_0008;
    #1;
    check("sel inside", {31'd0, sel}, 32'd1);
    check("rdata inside ARR", rdata, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
